// File: rtl/ddr3_burst_mover.sv
// Burst mover between the pipe FIFOs and the MIG DDR3 user interface.
// Writes drain ib_* into DDR3; reads refill ob_*, all on ui_clk.
module ddr3_burst_mover #(
  parameter int          BURST_LEN = 32,
  parameter logic [29:0] ADDR_INCR = 30'd8,
  parameter logic [29:0] ADDR_MAX  = 30'h0800_0000,
  parameter logic [6:0]  OB_LIMIT  = 7'd64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reads_en,
  input  logic         writes_en,
  input  logic         calib_done,
  output logic         ib_re,
  input  logic [255:0] ib_data,
  input  logic [6:0]   ib_count,
  input  logic         ib_valid,
  input  logic         ib_empty,
  output logic         ob_we,
  output logic [255:0] ob_data,
  input  logic [6:0]   ob_count,
  input  logic         ob_full,
  input  logic         app_rdy,
  output logic         app_en,
  output logic [2:0]   app_cmd,
  output logic [29:0]  app_addr,
  input  logic [255:0] app_rd_data,
  input  logic         app_rd_data_end,
  input  logic         app_rd_data_valid,
  input  logic         app_wdf_rdy,
  output logic         app_wdf_wren,
  output logic [255:0] app_wdf_data,
  output logic         app_wdf_end,
  output logic [31:0]  app_wdf_mask,
  output logic         ob_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  localparam logic [6:0] BL = 7'(BURST_LEN);

  state_t r_state, w_next;

  logic [29:0]  r_wr_ptr, r_rd_ptr;
  logic [29:0]  w_wr_sum, w_rd_sum, w_wr_nxt, w_rd_nxt;
  logic [6:0]   r_fetched, r_beats, r_issued, r_returned;
  logic [255:0] r_hold;
  logic         r_hold_full, r_ib_pend, r_cmd_done, r_dat_done;
  logic         r_ob_we, r_ovf;
  logic [255:0] r_ob_data;
  logic         w_cmd_ok, w_dat_ok, w_beat_done, w_unused;

  assign w_wr_sum = r_wr_ptr + ADDR_INCR;
  assign w_rd_sum = r_rd_ptr + ADDR_INCR;
  assign w_wr_nxt = (w_wr_sum >= ADDR_MAX) ? '0 : w_wr_sum;
  assign w_rd_nxt = (w_rd_sum >= ADDR_MAX) ? '0 : w_rd_sum;

  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = r_hold;
  assign app_wdf_mask = '0;
  assign ob_we        = r_ob_we;
  assign ob_data      = r_ob_data;
  assign ob_overflow  = r_ovf;
  assign w_unused     = app_rd_data_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    ib_re        = 1'b0;
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    w_cmd_ok     = 1'b0;
    w_dat_ok     = 1'b0;
    w_beat_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (calib_done && writes_en && ib_count >= BL)
          w_next = S_WRITE;
        else if (calib_done && reads_en && ob_count <= OB_LIMIT)
          w_next = S_READ;
      end
      S_WRITE: begin
        ib_re = !r_hold_full && !r_ib_pend &&
                (r_fetched < BL) && !ib_empty;
        app_en       = r_hold_full && !r_cmd_done;
        app_wdf_wren = r_hold_full && !r_dat_done;
        app_addr     = r_wr_ptr;
        w_cmd_ok     = app_en && app_rdy;
        w_dat_ok     = app_wdf_wren && app_wdf_rdy;
        // command and data handshakes may land in different cycles
        w_beat_done  = r_hold_full &&
                       (r_cmd_done || w_cmd_ok) &&
                       (r_dat_done || w_dat_ok);
        if (w_beat_done && r_beats == BL - 7'd1)
          w_next = S_IDLE;
      end
      S_READ: begin
        app_en   = r_issued < BL;
        app_cmd  = 3'b001;
        app_addr = r_rd_ptr;
        w_cmd_ok = app_en && app_rdy;
        if (r_returned == BL && r_issued == BL)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fetched   <= '0;
      r_beats     <= '0;
      r_issued    <= '0;
      r_returned  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ib_pend   <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_dat_done  <= 1'b0;
      r_ob_we     <= 1'b0;
      r_ob_data   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_ob_we   <= app_rd_data_valid;
      r_ob_data <= app_rd_data;
      if (app_rd_data_valid && ob_full) r_ovf <= 1'b1;
      if (r_state == S_IDLE) begin
        r_fetched   <= '0;
        r_beats     <= '0;
        r_issued    <= '0;
        r_returned  <= '0;
        r_hold_full <= 1'b0;
        r_ib_pend   <= 1'b0;
        r_cmd_done  <= 1'b0;
        r_dat_done  <= 1'b0;
      end else if (r_state == S_WRITE) begin
        if (ib_re) begin
          r_ib_pend <= 1'b1;
          r_fetched <= r_fetched + 7'd1;
        end
        if (ib_valid && r_ib_pend) begin
          r_hold      <= ib_data;
          r_hold_full <= 1'b1;
          r_ib_pend   <= 1'b0;
        end
        if (w_beat_done) begin
          r_hold_full <= 1'b0;
          r_cmd_done  <= 1'b0;
          r_dat_done  <= 1'b0;
          r_wr_ptr    <= w_wr_nxt;
          r_beats     <= r_beats + 7'd1;
        end else begin
          if (w_cmd_ok) r_cmd_done <= 1'b1;
          if (w_dat_ok) r_dat_done <= 1'b1;
        end
      end else begin
        if (w_cmd_ok) begin
          r_issued <= r_issued + 7'd1;
          r_rd_ptr <= w_rd_nxt;
        end
        if (app_rd_data_valid) r_returned <= r_returned + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_burst_mover.sv
// Directed bench for ddr3_burst_mover: FIFO and MIG models,
// a second instance with a small ADDR_MAX exercises pointer wrap.
module tb_ddr3_burst_mover;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         reads_en = 1'b0, writes_en = 1'b0, calib_done = 1'b0;
  logic [255:0] ib_data = '0;
  logic [6:0]   ib_count = '0, ob_count = '0;
  logic         ib_valid = 1'b0, ib_empty = 1'b0, ob_full = 1'b0;
  logic         app_rdy = 1'b1, app_wdf_rdy = 1'b1;
  logic [255:0] app_rd_data = '0;
  logic         app_rd_data_valid = 1'b0;

  logic         a_ib_re, a_ob_we, a_app_en, a_wren, a_wend, a_ovf;
  logic [255:0] a_ob_data, a_wdata;
  logic [2:0]   a_app_cmd;
  logic [29:0]  a_app_addr;
  logic [31:0]  a_mask;
  logic         b_ib_re, b_ob_we, b_app_en, b_wren, b_wend, b_ovf;
  logic [255:0] b_ob_data, b_wdata;
  logic [2:0]   b_app_cmd;
  logic [29:0]  b_app_addr;
  logic [31:0]  b_mask;

  ddr3_burst_mover dut_a (
    .clk(clk), .reset(reset), .reads_en(reads_en),
    .writes_en(writes_en), .calib_done(calib_done),
    .ib_re(a_ib_re), .ib_data(ib_data), .ib_count(ib_count),
    .ib_valid(ib_valid), .ib_empty(ib_empty),
    .ob_we(a_ob_we), .ob_data(a_ob_data), .ob_count(ob_count),
    .ob_full(ob_full), .app_rdy(app_rdy), .app_en(a_app_en),
    .app_cmd(a_app_cmd), .app_addr(a_app_addr),
    .app_rd_data(app_rd_data), .app_rd_data_end(1'b0),
    .app_rd_data_valid(app_rd_data_valid),
    .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(a_wren),
    .app_wdf_data(a_wdata), .app_wdf_end(a_wend),
    .app_wdf_mask(a_mask), .ob_overflow(a_ovf)
  );

  ddr3_burst_mover #(.ADDR_MAX(30'd256)) dut_b (
    .clk(clk), .reset(reset), .reads_en(reads_en),
    .writes_en(writes_en), .calib_done(calib_done),
    .ib_re(b_ib_re), .ib_data(ib_data), .ib_count(ib_count),
    .ib_valid(ib_valid), .ib_empty(ib_empty),
    .ob_we(b_ob_we), .ob_data(b_ob_data), .ob_count(ob_count),
    .ob_full(ob_full), .app_rdy(app_rdy), .app_en(b_app_en),
    .app_cmd(b_app_cmd), .app_addr(b_app_addr),
    .app_rd_data(app_rd_data), .app_rd_data_end(1'b0),
    .app_rd_data_valid(app_rd_data_valid),
    .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(b_wren),
    .app_wdf_data(b_wdata), .app_wdf_end(b_wend),
    .app_wdf_mask(b_mask), .ob_overflow(b_ovf)
  );

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [255:0] ib_word(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {8{w}};
  endfunction

  logic [29:0]  wr_log[$], rd_log[$], b_wr_log[$], wa_q[$];
  logic [255:0] wd_log[$], ob_log[$], wd_q[$];
  logic [2:0]   cmd_log[$];
  logic [255:0] mem [logic [29:0]];
  int           ibre_n = 0;
  int           ib_idx = 0;
  logic         rv [4];
  logic [29:0]  ra [4];

  initial for (int i = 0; i < 4; i++) begin
    rv[i] = 1'b0;
    ra[i] = '0;
  end

  // input FIFO, MIG memory and read-return models plus transaction logs
  always @(posedge clk) begin
    ib_valid <= a_ib_re;
    if (a_ib_re) begin
      ib_data <= ib_word(ib_idx);
      ib_idx  <= ib_idx + 1;
      ibre_n  = ibre_n + 1;
    end
    if (a_app_en && app_rdy) begin
      cmd_log.push_back(a_app_cmd);
      if (a_app_cmd == 3'b000) begin
        wr_log.push_back(a_app_addr);
        wa_q.push_back(a_app_addr);
      end else begin
        rd_log.push_back(a_app_addr);
      end
    end
    if (b_app_en && app_rdy && b_app_cmd == 3'b000)
      b_wr_log.push_back(b_app_addr);
    if (a_wren && app_wdf_rdy) begin
      wd_log.push_back(a_wdata);
      wd_q.push_back(a_wdata);
    end
    while (wa_q.size() > 0 && wd_q.size() > 0)
      mem[wa_q.pop_front()] = wd_q.pop_front();
    if (a_ob_we) ob_log.push_back(a_ob_data);
    app_rd_data_valid <= rv[3];
    app_rd_data <= mem.exists(ra[3]) ? mem[ra[3]] : '0;
    rv[3] <= rv[2]; ra[3] <= ra[2];
    rv[2] <= rv[1]; ra[2] <= ra[1];
    rv[1] <= rv[0]; ra[1] <= ra[0];
    rv[0] <= a_app_en && app_rdy && a_app_cmd == 3'b001;
    ra[0] <= a_app_addr;
  end

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); b_wr_log.delete();
    wd_log.delete(); ob_log.delete(); cmd_log.delete();
    wa_q.delete(); wd_q.delete();
    ibre_n = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int log_size(input int which);
    case (which)
      0: return wr_log.size();
      1: return wd_log.size();
      2: return rd_log.size();
      default: return ob_log.size();
    endcase
  endfunction

  task automatic wait_for(input int which, input int n,
                          input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick(1);
      if (log_size(which) >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_total++;
    if ({a_app_en, a_wren, a_wend, a_ib_re, a_ob_we, a_ovf} !== 6'b0) begin
      $display("FAIL reset_ctl got=%b want=000000",
               {a_app_en, a_wren, a_wend, a_ib_re, a_ob_we, a_ovf});
    end else n_pass++;
    n_total++;
    if (a_app_addr !== 30'd0 || a_app_cmd !== 3'd0) begin
      $display("FAIL reset_addr got=%h/%h want=0/0", a_app_addr, a_app_cmd);
    end else n_pass++;
    n_total++;
    if (a_wdata !== 256'd0 || a_ob_data !== 256'd0 || a_mask !== 32'd0) begin
      $display("FAIL reset_data got nonzero want=0");
    end else n_pass++;
    reset = 1'b0;
    writes_en = 1'b1; reads_en = 1'b1; ib_count = 7'd32;
    tick(10);
    n_total++;
    if (cmd_log.size() != 0) begin
      $display("FAIL calib_gate got=%0d cmds want=0", cmd_log.size());
    end else n_pass++;
    writes_en = 1'b0; reads_en = 1'b0; ib_count = 7'd0;
    calib_done = 1'b1;
    tick(2);
  endtask

  task automatic test_write_burst();
    bit ok;
    clear_logs();
    ib_count = 7'd32; writes_en = 1'b1;
    wait_for(0, 32, 400, ok);
    writes_en = 1'b0; ib_count = 7'd0;
    n_total++;
    if (!ok) $display("FAIL wr1_timeout got=%0d want=32", wr_log.size());
    else n_pass++;
    tick(10);
    n_total++;
    if (wr_log.size() != 32 || wd_log.size() != 32) begin
      $display("FAIL wr1_count got=%0d/%0d want=32/32",
               wr_log.size(), wd_log.size());
    end else n_pass++;
    n_total++;
    if (ibre_n != 32) $display("FAIL wr1_ib_re got=%0d want=32", ibre_n);
    else n_pass++;
    for (int i = 0; i < 32 && i < wr_log.size(); i++) begin
      n_total++;
      if (wr_log[i] !== 30'(i * 8) || wd_log[i] !== ib_word(i)) begin
        $display("FAIL wr1_beat%0d got=%h want=%h", i, wr_log[i], 30'(i * 8));
      end else n_pass++;
    end
  endtask

  task automatic test_read_back();
    bit ok;
    clear_logs();
    ob_count = 7'd0; reads_en = 1'b1;
    wait_for(2, 32, 300, ok);
    reads_en = 1'b0;
    n_total++;
    if (!ok) $display("FAIL rd_timeout got=%0d want=32", rd_log.size());
    else n_pass++;
    wait_for(3, 32, 100, ok);
    tick(10);
    n_total++;
    if (ob_log.size() != 32 || rd_log.size() != 32) begin
      $display("FAIL rd_count got=%0d/%0d want=32/32",
               ob_log.size(), rd_log.size());
    end else n_pass++;
    for (int i = 0; i < 32 && i < ob_log.size() && i < rd_log.size(); i++) begin
      n_total++;
      if (ob_log[i] !== ib_word(i) || rd_log[i] !== 30'(i * 8)) begin
        $display("FAIL rd_word%0d got=%h want=%h", i, ob_log[i][31:0],
                 ib_word(i) & 256'hFFFF_FFFF);
      end else n_pass++;
    end
  endtask

  task automatic test_wdf_stall();
    bit ok;
    clear_logs();
    app_wdf_rdy = 1'b0; ib_count = 7'd32; writes_en = 1'b1;
    wait_for(0, 1, 50, ok);
    writes_en = 1'b0; ib_count = 7'd0;
    tick(5);
    n_total++;
    if (wr_log.size() != 1 || wd_log.size() != 0 ||
        a_wren !== 1'b1 || a_app_en !== 1'b0) begin
      $display("FAIL stall_hold got=%0d/%0d/%b/%b want=1/0/1/0",
               wr_log.size(), wd_log.size(), a_wren, a_app_en);
    end else n_pass++;
    app_wdf_rdy = 1'b1;
    tick(1);
    n_total++;
    if (wr_log.size() != 1 || wd_log.size() != 1) begin
      $display("FAIL stall_release got=%0d/%0d want=1/1",
               wr_log.size(), wd_log.size());
    end else n_pass++;
    wait_for(1, 32, 400, ok);
    tick(10);
    n_total++;
    if (wr_log.size() != 32 || wd_log.size() != 32) begin
      $display("FAIL stall_count got=%0d/%0d want=32/32",
               wr_log.size(), wd_log.size());
    end else n_pass++;
    n_total++;
    if (wr_log.size() < 32 || wr_log[0] !== 30'd256 || wr_log[31] !== 30'd504 ||
        wd_log.size() < 1 || wd_log[0] !== ib_word(32)) begin
      $display("FAIL stall_addr got=%h want=100", wr_log[0]);
    end else n_pass++;
  endtask

  task automatic test_addr_wrap();
    bit ok;
    clear_logs();
    ib_count = 7'd32; writes_en = 1'b1;
    wait_for(0, 32, 400, ok);
    writes_en = 1'b0; ib_count = 7'd0;
    tick(10);
    n_total++;
    if (wr_log.size() != 32 || wr_log[0] !== 30'd512 || wr_log[31] !== 30'd760) begin
      $display("FAIL wrap_a got=%h want=200", wr_log[0]);
    end else n_pass++;
    n_total++;
    if (b_wr_log.size() != 32) begin
      $display("FAIL wrap_b_count got=%0d want=32", b_wr_log.size());
    end else n_pass++;
    for (int i = 0; i < b_wr_log.size() && i < 32; i++) begin
      n_total++;
      if (b_wr_log[i] !== 30'(i * 8)) begin
        $display("FAIL wrap_b%0d got=%h want=%h", i, b_wr_log[i], 30'(i * 8));
      end else n_pass++;
    end
  endtask

  task automatic test_priority();
    bit ok;
    clear_logs();
    ib_count = 7'd40; ob_count = 7'd0;
    writes_en = 1'b1; reads_en = 1'b1;
    wait_for(0, 32, 400, ok);
    writes_en = 1'b0; ib_count = 7'd0;
    wait_for(2, 32, 300, ok);
    reads_en = 1'b0;
    n_total++;
    if (!ok) $display("FAIL prio_timeout got=%0d want=32", rd_log.size());
    else n_pass++;
    wait_for(3, 32, 100, ok);
    tick(10);
    n_total++;
    if (cmd_log.size() != 64 || cmd_log[0] !== 3'b000 || cmd_log[31] !== 3'b000 ||
        cmd_log[32] !== 3'b001) begin
      $display("FAIL prio_order got=%0d cmds want=64 write-first",
               cmd_log.size());
    end else n_pass++;
    n_total++;
    if (rd_log.size() < 1 || ob_log.size() != 32 || rd_log[0] !== 30'd256 ||
        ob_log[0] !== ib_word(32) || ob_log[31] !== ib_word(63)) begin
      $display("FAIL prio_read got=%0d words want=32 from 100",
               ob_log.size());
    end else n_pass++;
  endtask

  task automatic test_ob_limit();
    bit ok;
    clear_logs();
    ob_count = 7'd65; reads_en = 1'b1;
    tick(20);
    n_total++;
    if (rd_log.size() != 0) begin
      $display("FAIL ob_limit65 got=%0d want=0", rd_log.size());
    end else n_pass++;
    ob_count = 7'd64; ob_full = 1'b1;
    wait_for(2, 1, 10, ok);
    reads_en = 1'b0;
    n_total++;
    if (!ok) $display("FAIL ob_limit64 got=0 want=start");
    else n_pass++;
    wait_for(3, 32, 300, ok);
    ob_full = 1'b0;
    tick(5);
    n_total++;
    if (a_ovf !== 1'b1 || ob_log.size() != 32) begin
      $display("FAIL overflow got=%b/%0d want=1/32", a_ovf, ob_log.size());
    end else n_pass++;
    n_total++;
    if (rd_log[0] !== 30'd512 || ob_log[0] !== ib_word(64)) begin
      $display("FAIL ovf_data got=%h want=200", rd_log[0]);
    end else n_pass++;
    ob_count = 7'd0;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    clear_logs();
    ib_count = 7'd32; writes_en = 1'b1;
    wait_for(0, 10, 200, ok);
    for (int c = 0; c < 10 && a_app_en !== 1'b1; c++) tick(1);
    n_total++;
    if (wr_log.size() != 10 || a_app_en !== 1'b1) begin
      $display("FAIL mid_setup got=%0d/%b want=10/1", wr_log.size(), a_app_en);
    end else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({a_app_en, a_wren, a_ib_re, a_ovf, a_ob_we} !== 5'b0 ||
        a_app_addr !== 30'd0) begin
      $display("FAIL mid_reset got=%b addr=%h want=00000 addr=0",
               {a_app_en, a_wren, a_ib_re, a_ovf, a_ob_we}, a_app_addr);
    end else n_pass++;
    tick(3);
    clear_logs();
    reset = 1'b0;
    wait_for(0, 1, 50, ok);
    writes_en = 1'b0;
    n_total++;
    if (!ok || wr_log[0] !== 30'd0 || b_wr_log[0] !== 30'd0) begin
      $display("FAIL post_reset_addr got=%h want=0", ok ? wr_log[0] : 30'h3fffffff);
    end else n_pass++;
    wait_for(0, 32, 400, ok);
    ib_count = 7'd0;
    tick(10);
    n_total++;
    if (wr_log.size() != 32 || wr_log[31] !== 30'd248) begin
      $display("FAIL post_reset_burst got=%0d want=32", wr_log.size());
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_back();
    test_wdf_stall();
    test_addr_wrap();
    test_priority();
    test_ob_limit();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=done");
    $fatal(1, "timeout");
  end

endmodule
